// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with architectural HI/LO registers.
// Result is computed at start and released after a fixed busy window.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        real_busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int CW = 16;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   hi_tmp_q, hi_tmp_d;
    logic [31:0]   lo_tmp_q, lo_tmp_d;

    logic          is_mul;
    logic          is_div;
    logic [63:0]   a_sx, b_sx;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   abs_a, abs_b;
    logic [31:0]   uq, ur;
    logic [31:0]   sq, sr;
    logic [31:0]   dq, dr;

    assign is_mul = (md_op == 4'd1) || (md_op == 4'd2);
    assign is_div = (md_op == 4'd3) || (md_op == 4'd4);

    assign a_sx   = {{32{rs_val[31]}}, rs_val};
    assign b_sx   = {{32{rt_val[31]}}, rt_val};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide on magnitudes; keeps 0x80000000 / -1 free of overflow traps.
    always_comb begin
        abs_a = rs_val;
        abs_b = rt_val;
        if (md_op == 4'd3) begin
            abs_a = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
            abs_b = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
        end
    end

    assign uq = (rt_val == 32'd0) ? 32'd0 : abs_a / abs_b;
    assign ur = (rt_val == 32'd0) ? 32'd0 : abs_a % abs_b;
    assign sq = (rs_val[31] ^ rt_val[31]) ? (~uq + 32'd1) : uq;
    assign sr = rs_val[31] ? (~ur + 32'd1) : ur;
    assign dq = (md_op == 4'd3) ? sq : uq;
    assign dr = (md_op == 4'd3) ? sr : ur;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        unique case (state_q)
            IDLE: begin
                if (is_mul) begin
                    hi_tmp_d = (md_op == 4'd1) ? prod_s[63:32] : prod_u[63:32];
                    lo_tmp_d = (md_op == 4'd1) ? prod_s[31:0] : prod_u[31:0];
                    cnt_d    = CW'(MULT_CYCLES);
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end else if (is_div) begin
                    // Divide by zero leaves HI/LO as they were.
                    hi_tmp_d = (rt_val == 32'd0) ? hi_q : dr;
                    lo_tmp_d = (rt_val == 32'd0) ? lo_q : dq;
                    cnt_d    = CW'(DIV_CYCLES);
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end else if (md_op == 4'd5) begin
                    hi_d = rs_val;
                end else if (md_op == 4'd6) begin
                    lo_d = rs_val;
                end
            end
            RUN: begin
                if (cnt_q > CW'(1)) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    hi_d    = hi_tmp_q;
                    lo_d    = lo_tmp_q;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign real_busy = busy_q | is_mul | is_div;
    assign md_out    = (md_op == 4'd7) ? hi_q :
                       (md_op == 4'd8) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: mult/div results, busy window, mt/mf,
// divide by zero, ignored ops while busy and asynchronous reset.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        real_busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int n_checks = 0;
    int n_fail   = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .busy      (busy),
        .real_busy (real_busy),
        .hi        (hi),
        .lo        (lo),
        .md_out    (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply op at negedge, verify real_busy in the start cycle, clock it in.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_rb);
        @(negedge clk);
        md_op  = op;
        rs_val = a;
        rt_val = b;
        #1;
        check("real_busy_start", {31'd0, real_busy}, {31'd0, exp_rb});
        @(posedge clk);
        #1;
        md_op = 4'd0;
    endtask

    // Count edges until busy drops; caller is #1 after the start edge.
    task automatic wait_busy(input string tag, input int exp_n);
        int n;
        n = 0;
        check({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_busy_len"}, n, exp_n);
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        md_op  = 4'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_md_out", md_out, 32'd0);
        reset = 1'b0;

        issue(4'd1, 32'hFFFFFFFD, 32'd7, 1'b1);
        wait_busy("mult", 5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFEB);

        issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b1);
        wait_busy("multu", 5);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);

        issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_busy("div", 10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        issue(4'd4, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_busy("divu", 10);
        check("divu_lo", lo, 32'h7FFFFFFC);
        check("divu_hi", hi, 32'h00000001);

        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_busy("divovf", 10);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'h00000000);

        issue(4'd5, 32'h12345678, 32'd0, 1'b0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(4'd6, 32'h9ABCDEF0, 32'd0, 1'b0);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        md_op = 4'd7;
        #1;
        check("mfhi_out", md_out, 32'h12345678);
        check("mfhi_rb", {31'd0, real_busy}, 32'd0);
        md_op = 4'd8;
        #1;
        check("mflo_out", md_out, 32'h9ABCDEF0);
        md_op = 4'd0;
        #1;
        check("none_out", md_out, 32'd0);

        // Divide by zero, with mthi and mult injected mid-flight.
        issue(4'd5, 32'h00000011, 32'd0, 1'b0);
        issue(4'd6, 32'h00000022, 32'd0, 1'b0);
        issue(4'd3, 32'd5, 32'd0, 1'b1);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            if (n == 3) begin
                md_op  = 4'd5;
                rs_val = 32'hDEADBEEF;
            end else if (n == 4) begin
                md_op  = 4'd1;
                rs_val = 32'd3;
                rt_val = 32'd3;
            end else if (n == 5) begin
                md_op = 4'd7;
                #1;
                check("dz_mfhi_old", md_out, 32'h00000011);
                check("dz_rb_busy", {31'd0, real_busy}, 32'd1);
            end else begin
                md_op = 4'd0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        md_op = 4'd0;
        check("dz_busy_len", n, 10);
        check("dz_hi", hi, 32'h00000011);
        check("dz_lo", lo, 32'h00000022);
        @(posedge clk);
        #1;
        check("dz_no_restart", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a mult.
        issue(4'd1, 32'd3, 32'd4, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("arst_idle_lo", lo, 32'd0);

        issue(4'd1, 32'd6, 32'd7, 1'b1);
        wait_busy("mult2", 5);
        check("mult2_hi", hi, 32'd0);
        check("mult2_lo", lo, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Sits alongside the E-stage ALU. It receives the decoded multiply/divide op plus forwarded rs/rt operands, and holds the architectural HI/LO registers.
- Produces `busy` and `real_busy`; the hazard/stall controller uses these to freeze the D stage whenever a multiply/divide-class instruction reaches D while the unit is occupied.
- Supplies the mfhi/mflo read data to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, number of busy cycles for div/divu (must be ≥1).

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- md_op  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
- rt_val  input  32  forwarded rt operand (divisor / multiplier).
- busy  output  1  registered; high while a mult/div is in flight.
- real_busy  output  1  combinational: busy OR (md_op in 1..4); consumed by the stall controller.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- md_out  output  32  combinational: hi when md_op=7, lo when md_op=8, else 0.

Behaviour:
- Reset values: busy=0, hi=0, lo=0, cnt=0, state=IDLE, result temps=0. Reset asserted mid-operation aborts the operation; HI/LO read 0 afterwards.
- State machine has two states, IDLE and RUN.
- IDLE, with md_op in 1..4 at a rising edge (start edge T0):
  - Latch the full result into hi_tmp/lo_tmp.
  - Load cnt = MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - busy<=1, go to RUN.
- RUN, each edge:
  - If cnt>1, decrement cnt.
  - If cnt==1: hi<=hi_tmp, lo<=lo_tmp, busy<=0, cnt<=0, go to IDLE.
  - Net effect: busy is high for exactly N cycles after T0, and the new HI/LO are visible from edge T0+N.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = product[63:32], LO = product[31:0].
  - multu: same split, unsigned product.
  - div: LO = signed quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div/divu with rt_val=0: still busy for DIV_CYCLES; on completion HI and LO keep their pre-start values (no exception raised).
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
- mthi/mtlo (ops 5,6) in IDLE: hi (or lo) <= rs_val at that edge; no busy phase.
- Any md_op arriving while busy=1 (ops 1-6): ignored, and the in-flight op is unaffected. The stall controller normally prevents this; the ignore is defensive and must not corrupt state.
- mfhi/mflo during RUN return the old HI/LO (stall prevents this architecturally; the block itself does not block it).
- real_busy is high in the start cycle itself, so a following mult/div/mf/mt in D stalls immediately.
- Back-to-back: a new start is accepted on the edge after busy drops.

Test Plan:
- reset; md_op=1, rs=0xFFFFFFFD(-3), rt=7 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB; real_busy=1 in the start cycle.
- md_op=2, rs=0xFFFFFFFF, rt=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- md_op=3, rs=0xFFFFFFF9(-7), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with md_op=4 -> lo=0x7FFFFFFC, hi=1.
- md_op=5 rs=0x12345678, next cycle md_op=6 rs=0x9ABCDEF0, then md_op=7 -> md_out=0x12345678; md_op=8 -> md_out=0x9ABCDEF0; busy never asserts.
- Divide by zero after hi=0x11,lo=0x22 -> busy 10 cycles, hi/lo stay 0x11/0x22. Issue md_op=5 mid-busy -> hi unchanged.
- Start mult, assert reset at cycle 3 -> busy=0, hi=lo=0 immediately (asynchronous); after release a new mult completes normally.
